// File: rtl/mem_latency_responder.sv
// ---------------------------------------------------------------------------
// mem_latency_responder
//
// Memory-side responder for one CPU memory port (fetch or data). Accepts at
// most one 16-bit read or write per cycle, with no backpressure. Read data
// returns exactly LATENCY cycles after the request cycle through a fully
// pipelined shift chain. An in-flight read counter is exported, and `cancel`
// squashes every outstanding read on a pipeline flush.
//
// Optional feature macro: MEM_MISALIGN_ERR_EN
//   defined     : req_addr[0]=1 is misaligned; such reads return data 0 with
//                 rsp_err=1, and such writes are dropped.
//   not defined : req_addr[0] is ignored and rsp_err is always 0.
//
// Parameters
//   LATENCY   request-to-response cycles, 1..8
//   ADDR_W    byte-address width; the array holds 2^(ADDR_W-1) 16-bit words
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset (array contents are kept)
//   req_en     request present this cycle
//   req_wr     1 = write, 0 = read
//   req_addr   byte address; word index = req_addr[ADDR_W-1:1]
//   req_wdata  write data
//   cancel     squash all in-flight reads
//   rsp_valid  one-cycle pulse per read response
//   rsp_data   read data, 0 when rsp_valid=0
//   rsp_err    misaligned-read flag, qualified by rsp_valid
//   inflight   accepted reads not yet responded, 0..LATENCY
// ---------------------------------------------------------------------------
module mem_latency_responder #(
    parameter int LATENCY = 4,
    parameter int ADDR_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_en,
    input  logic              req_wr,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [15:0]       req_wdata,
    input  logic              cancel,
    output logic              rsp_valid,
    output logic [15:0]       rsp_data,
    output logic              rsp_err,
    output logic [3:0]        inflight
);

    localparam int IDX_W = ADDR_W - 1;
    localparam int WORDS = 1 << IDX_W;

`ifdef MEM_MISALIGN_ERR_EN
    localparam logic ERR_EN = 1'b1;
`else
    localparam logic ERR_EN = 1'b0;
`endif

    // Word array; deliberately not reset.
    logic [15:0] mem_q [WORDS];

    // Stage i of the read pipeline; stage LATENCY drives rsp_*.
    logic [LATENCY:1]        vld_pipe_q, vld_pipe_d;
    logic [LATENCY:1][15:0]  dat_pipe_q, dat_pipe_d;
    logic [LATENCY:1]        err_pipe_q, err_pipe_d;
    logic [3:0]              inflight_q, inflight_d;

    logic [IDX_W-1:0] word_idx;
    logic             misalign;
    logic             rd_acc;
    logic             wr_acc;

    assign word_idx = req_addr[ADDR_W-1:1];
    // With the feature off, ERR_EN folds this to 0 and the LSB is ignored.
    assign misalign = ERR_EN & req_addr[0];
    assign rd_acc   = req_en & ~req_wr;
    assign wr_acc   = req_en &  req_wr & ~misalign;

    // Writes commit at the accepting edge, regardless of cancel.
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem_q[word_idx] <= req_wdata;
        end
    end

    // Pipeline next state. Invalid stages always carry zero data/err, so
    // the last stage can drive rsp_data/rsp_err straight from its flops.
    always_comb begin
        vld_pipe_d = '0;
        dat_pipe_d = '0;
        err_pipe_d = '0;

        if (!cancel) begin
            for (int i = 2; i <= LATENCY; i++) begin
                vld_pipe_d[i] = vld_pipe_q[i-1];
                dat_pipe_d[i] = dat_pipe_q[i-1];
                err_pipe_d[i] = err_pipe_q[i-1];
            end
        end

        // A read in the cancel cycle is younger than the flush and survives.
        vld_pipe_d[1] = rd_acc;
        dat_pipe_d[1] = (rd_acc && !misalign) ? mem_q[word_idx] : 16'h0000;
        err_pipe_d[1] = rd_acc & misalign;
    end

    // Count: +1 per accepted read, -1 as a response leaves the last stage.
    always_comb begin
        if (cancel) begin
            inflight_d = {3'b000, rd_acc};
        end else begin
            inflight_d = inflight_q + {3'b000, rd_acc} - {3'b000, vld_pipe_q[LATENCY]};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_pipe_q <= '0;
            dat_pipe_q <= '0;
            err_pipe_q <= '0;
            inflight_q <= '0;
        end else begin
            vld_pipe_q <= vld_pipe_d;
            dat_pipe_q <= dat_pipe_d;
            err_pipe_q <= err_pipe_d;
            inflight_q <= inflight_d;
        end
    end

    assign rsp_valid = vld_pipe_q[LATENCY];
    assign rsp_data  = dat_pipe_q[LATENCY];
    assign rsp_err   = err_pipe_q[LATENCY];
    assign inflight  = inflight_q;

endmodule

// File: tb/tb_mem_latency_responder.sv
// ---------------------------------------------------------------------------
// tb_mem_latency_responder
//
// Scoreboard bench. The driver applies requests on the falling edge and, for
// each accepted read, pushes the expected response (due edge, data, err) into
// a queue computed from a plain word-array model of memory. A monitor
// sampling 1 time unit after every rising edge pops and compares responses
// and checks the in-flight count against the number of outstanding entries.
// ---------------------------------------------------------------------------
module tb_mem_latency_responder;

    localparam int LAT = 4;
    localparam int AW  = 16;

`ifdef MEM_MISALIGN_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic          req_en;
    logic          req_wr;
    logic [AW-1:0] req_addr;
    logic [15:0]   req_wdata;
    logic          cancel;
    logic          rsp_valid;
    logic [15:0]   rsp_data;
    logic          rsp_err;
    logic [3:0]    inflight;

    mem_latency_responder #(.LATENCY(LAT), .ADDR_W(AW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_en    (req_en),
        .req_wr    (req_wr),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .cancel    (cancel),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .rsp_err   (rsp_err),
        .inflight  (inflight)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          due;
        logic [15:0] data;
        logic        err;
    } exp_t;

    exp_t        sb[$];
    logic [15:0] model [32];   // test traffic stays in byte addresses 0..63
    int          edge_cnt = 0;
    int          n_cmp    = 0;
    int          n_bad    = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, edge_cnt);
        end
    endtask

    // Monitor: outputs reflect the state after edge number edge_cnt.
    always @(posedge clk) begin
        #1;
        edge_cnt++;
        chk("inflight", {28'd0, inflight}, sb.size());
        if (sb.size() > 0 && sb[0].due == edge_cnt) begin
            chk("rsp_valid", {31'd0, rsp_valid}, 32'd1);
            chk("rsp_data",  {16'd0, rsp_data},  {16'd0, sb[0].data});
            chk("rsp_err",   {31'd0, rsp_err},   {31'd0, sb[0].err});
            void'(sb.pop_front());
        end else begin
            chk("idle_valid", {31'd0, rsp_valid}, 32'd0);
            chk("idle_data",  {16'd0, rsp_data},  32'd0);
            chk("idle_err",   {31'd0, rsp_err},   32'd0);
        end
    end

    // One request cycle; the upcoming rising edge is edge_cnt+1.
    task automatic drive(input bit en, input bit wr, input logic [15:0] addr,
                         input logic [15:0] wd, input bit cn);
        logic       mis;
        logic [4:0] idx;
        @(negedge clk);
        req_en    = en;
        req_wr    = wr;
        req_addr  = addr;
        req_wdata = wd;
        cancel    = cn;
        if (cn) sb.delete();
        if (en) begin
            mis = ERR_EN && addr[0];
            idx = addr[5:1];
            if (wr) begin
                if (!mis) model[idx] = wd;
            end else begin
                // accepted at edge_cnt+1, visible after edge_cnt+LAT
                sb.push_back(exp_t'{edge_cnt + LAT, mis ? 16'h0000 : model[idx], mis});
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        req_en = 1'b0;
        cancel = 1'b0;
        rst_n  = 1'b0;
        sb.delete();
        @(negedge clk);
        rst_n  = 1'b1;
    endtask

    initial begin
        rst_n     = 1'b0;
        req_en    = 1'b0;
        req_wr    = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        cancel    = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Preload: words 0..7 = 16'h1000+i, the rest random.
        for (int i = 0; i < 32; i++) begin
            logic [15:0] a;
            logic [15:0] v;
            a = 16'(i * 2);
            v = (i < 8) ? 16'(16'h1000 + i) : 16'($urandom);
            drive(1'b1, 1'b1, a, v, 1'b0);
        end

        // Single read after write.
        drive(1'b1, 1'b1, 16'h0010, 16'hBEEF, 1'b0);
        drive(1'b1, 1'b0, 16'h0010, 16'h0, 1'b0);
        idle(6);

        // Streaming reads of words 0..7.
        for (int i = 0; i < 8; i++) drive(1'b1, 1'b0, 16'(i * 2), 16'h0, 1'b0);
        idle(6);

        // Cancel on the third of three reads.
        drive(1'b1, 1'b0, 16'h0002, 16'h0, 1'b0);
        drive(1'b1, 1'b0, 16'h0004, 16'h0, 1'b0);
        drive(1'b1, 1'b0, 16'h0006, 16'h0, 1'b1);
        idle(6);

        // Reset mid-operation, then data survives.
        drive(1'b1, 1'b0, 16'h0008, 16'h0, 1'b0);
        drive(1'b1, 1'b0, 16'h000A, 16'h0, 1'b0);
        pulse_reset();
        idle(6);
        drive(1'b1, 1'b0, 16'h0010, 16'h0, 1'b0);
        idle(6);

        // Misaligned write/read, then aligned read of the same word.
        drive(1'b1, 1'b1, 16'h0021, 16'h1234, 1'b0);
        drive(1'b1, 1'b0, 16'h0021, 16'h0, 1'b0);
        drive(1'b1, 1'b0, 16'h0020, 16'h0, 1'b0);
        idle(6);

        // Random traffic with occasional cancel and reset.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 299) == 0) begin
                pulse_reset();
            end else begin
                drive(($urandom % 4) != 0, ($urandom % 3) == 0,
                      16'($urandom_range(0, 63)), 16'($urandom),
                      ($urandom % 20) == 0);
            end
        end

        idle(LAT + 8);
        chk("drain", sb.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
